// File: rtl/point_dispatch_ctrl.sv
// Point dispatch controller: feeds point indices to validator cores, retires their verdicts
// round-robin and queues the selected indices in a show-ahead result FIFO.
module point_dispatch_ctrl #(
   parameter int unsigned IDX_W      = 32,
   parameter int unsigned CORES      = 8,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   mode,
   input  logic [IDX_W-1:0]       point_cloud_size,
   input  logic [CORES-1:0]       core_done,
   input  logic [CORES-1:0]       core_outlier,
   output logic [CORES-1:0]       core_load,
   output logic [CORES*IDX_W-1:0] core_idx,
   output logic                   cache_adv,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       outlier_count,
   output logic [CNT_W-1:0]       retired_count
);

   localparam int unsigned RR_W  = (CORES > 1) ? $clog2(CORES) : 1;
   localparam int unsigned SW    = RR_W + 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
   state_e state_q, state_d;

   logic [IDX_W-1:0]       size_q, next_idx_q, push_idx;
   logic                   mode_q;
   logic [CORES-1:0]       busy_q;
   logic [RR_W-1:0]        rr_q, ld_c, rt_c;
   logic [SW-1:0]          sum;
   logic [CORES*IDX_W-1:0] idx_q;
   logic [CNT_W-1:0]       retired_q, outlier_q;
   logic [IDX_W-1:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_q, rd_q;
   logic [CW-1:0]          count_q;
   logic start_ok, active, any_free, found, selected, full, dispatch, retire, push, pop;

   assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
   assign active   = (state_q == StRun) && !pause && !reset;
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign selected = core_outlier[rt_c] ^ mode_q;
   assign dispatch = active && (next_idx_q < size_q) && any_free;
   // A selected verdict with a full FIFO waits in its core; a same-cycle pop does not help.
   assign retire   = active && found && !(selected && full);
   assign push     = retire && selected;
   assign pop      = out_valid && out_ready;

   always_comb begin
      any_free = 1'b0;
      ld_c     = '0;
      for (int c = int'(CORES) - 1; c >= 0; c--) begin
         if (!busy_q[c]) begin
            any_free = 1'b1;
            ld_c     = RR_W'(c);
         end
      end
   end

   always_comb begin
      found = 1'b0;
      rt_c  = '0;
      sum   = '0;
      for (int k = 0; k < int'(CORES); k++) begin
         sum = {1'b0, rr_q} + SW'(k);
         if (sum >= SW'(CORES)) sum = sum - SW'(CORES);
         if (!found && busy_q[sum[RR_W-1:0]] && core_done[sum[RR_W-1:0]]) begin
            found = 1'b1;
            rt_c  = sum[RR_W-1:0];
         end
      end
   end

   always_comb begin
      push_idx = '0;
      for (int c = 0; c < int'(CORES); c++) begin
         if (rt_c == RR_W'(c)) push_idx = idx_q[c*IDX_W +: IDX_W];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_ok) state_d = (point_cloud_size == '0) ? StDone : StRun;
         end
         StRun: begin
            if ((next_idx_q == size_q) && (busy_q == '0)) state_d = StDrain;
         end
         StDrain: begin
            if (count_q == '0) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q == StRun) || (state_q == StDrain);
      done      = (state_q == StDone);
      cache_adv = dispatch;
      core_load = '0;
      core_idx  = idx_q;
      for (int c = 0; c < int'(CORES); c++) begin
         if (dispatch && (ld_c == RR_W'(c))) begin
            core_load[c]               = 1'b1;
            core_idx[c*IDX_W +: IDX_W] = next_idx_q;
         end
      end
      out_valid = (count_q != '0);
      out_idx   = out_valid ? mem_q[rd_q] : '0;
   end

   assign retired_count = retired_q;
   assign outlier_count = outlier_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         size_q     <= '0;
         mode_q     <= 1'b0;
         next_idx_q <= '0;
         busy_q     <= '0;
         rr_q       <= '0;
         idx_q      <= '0;
         retired_q  <= '0;
         outlier_q  <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
      end else if (start_ok) begin
         size_q     <= point_cloud_size;
         mode_q     <= mode;
         next_idx_q <= '0;
         retired_q  <= '0;
         outlier_q  <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
      end else begin
         if (dispatch) begin
            next_idx_q <= next_idx_q + IDX_W'(1);
            idx_q      <= core_idx;
         end
         for (int c = 0; c < int'(CORES); c++) begin
            if (retire && (rt_c == RR_W'(c)))         busy_q[c] <= 1'b0;
            else if (dispatch && (ld_c == RR_W'(c))) busy_q[c] <= 1'b1;
         end
         if (retire) begin
            rr_q <= (rt_c == RR_W'(CORES - 1)) ? '0 : rt_c + RR_W'(1);
            if (retired_q != '1) retired_q <= retired_q + CNT_W'(1);
            if (core_outlier[rt_c] && (outlier_q != '1)) outlier_q <= outlier_q + CNT_W'(1);
         end
         if (push) wr_q <= wr_q + PTR_W'(1);
         if (pop)  rd_q <= rd_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= push_idx;
   end

endmodule

// File: doc/point_dispatch_ctrl.md
Name: point_dispatch_ctrl

Overview:
Parametrised successor to the validation controller. It hands point indices to CORES validator cores, collects each core's inlier/outlier verdict and pushes selected point indices into an internal parametrised FIFO. The FIFO drains over a valid/ready stream. It sits between the point cache/feeder and the outlier readback path. New relative to the previous generation: round-robin retire arbitration, FIFO backpressure with no lost results, selectable emit mode, a restartable start/done handshake and statistics counters.

Parameters:
IDX_W, 32, width of point indices and point-cloud size
CORES, 8, number of validator cores driven (1..32)
FIFO_DEPTH, 64, result FIFO entries; power of two, at least 2
CNT_W, 32, width of statistics counters

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a run (accepted only in IDLE or DONE)
pause  in  1  freezes dispatch and retire while high
mode  in  1  0 = emit outlier indices, 1 = emit inlier indices; sampled at start
point_cloud_size  in  IDX_W  number of points in this run; sampled at start
core_done  in  CORES  per-core verdict ready; held high until that core's core_load
core_outlier  in  CORES  per-core verdict, valid while core_done is high
core_load  out  CORES  one-cycle pulse; core loads core_idx and resets
core_idx  out  CORES*IDX_W  index assigned to each core; slice c is bits [(c+1)*IDX_W-1 -: IDX_W]
cache_adv  out  1  one-cycle pulse per dispatch; cache advances to the next point
out_idx  out  IDX_W  FIFO head index (show-ahead)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_idx
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
outlier_count  out  CNT_W  outliers found in the current run
retired_count  out  CNT_W  verdicts retired in the current run

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO emptied; per-core busy flags and round-robin pointer rr cleared. A mid-run reset aborts the run with no further core_load.
- States:
  - IDLE: start with size>0 goes to RUN; start with size==0 goes to DONE. Both clear the counters, next_idx and the FIFO.
  - RUN: dispatch and retire. Go to DRAIN when next_idx==size and no core is busy.
  - DRAIN: wait for the FIFO to empty, then go to DONE.
  - DONE: done=1. start re-enters as from IDLE. start is ignored in RUN and DRAIN.
- Dispatch, in RUN with pause=0, at most one per cycle:
  - Condition: next_idx<size and a free core exists.
  - Target is the lowest-index free core c. core_load[c] pulses, core_idx slice c is set to next_idx, cache_adv pulses, next_idx increments, and c is marked busy.
  - The first dispatch happens in the cycle after start is accepted.
- Retire, in RUN with pause=0, at most one per cycle:
  - Candidate: the first core at or after rr, searching cyclically, with busy=1 and core_done=1. core_done on a non-busy core is ignored.
  - A verdict is selected when core_outlier XOR mode is 1.
  - If the verdict is selected and the FIFO count==FIFO_DEPTH, the retire stalls. The core stays busy and rr is unchanged, even if a pop happens in the same cycle.
  - Otherwise, at the clock edge: push core_idx[c] if selected; increment retired_count; increment outlier_count if core_outlier=1; clear busy[c]; set rr=(c+1) mod CORES.
  - A core retired in cycle t can be dispatched at t+1 at the earliest.
- Results leave in retire order. out_valid rises one cycle after the push edge.
- FIFO pop happens on out_valid&out_ready. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- pause does not stop FIFO draining. Verdicts that arrive during pause are retained by the core and retired after pause drops.
- Counters saturate at all-ones and hold until the next start.

Test Plan:
- CORES=4, start with size=0 -> done=1 the cycle after start; no core_load or cache_adv; out_valid stays 0.
- CORES=4, size=4, mode=0, out_ready=1; cores 0..3 answer done together, with indices 1 and 3 as outliers -> core_load=0001,0010,0100,1000 on consecutive cycles; out_idx stream 1,3; retired_count=4, outlier_count=2; done after drain.
- Same stimulus with mode=1 -> stream 0,2; outlier_count still 2.
- FIFO_DEPTH=4, CORES=2, size=8, all outliers, out_ready=0 -> 4 entries held, retire stalls, core_done stays high, no extra push; then out_ready=1 -> indices 0..7 emerge in order, then done.
- pause=1 for 10 cycles mid-run with core_done high -> no core_load or retire during pause while the FIFO keeps draining; retire resumes in the first cycle after pause falls.
- reset asserted mid-run with 3 FIFO entries -> all outputs 0 next cycle, out_valid=0; a following start with size=2 completes normally.
